// File: rtl/crack_pkg.sv
// Shared types and constants for the ARC4 crack scheduler and its workers.
package crack_pkg;

   localparam int unsigned KEY_W_DEF   = 24;
   localparam logic [7:0]  CT_LEN_ADDR = 8'd0;

   typedef enum logic [2:0] {
      StIdle,
      StCopy,
      StLaunch,
      StRun,
      StDoneGood,
      StDoneBad
   } sched_state_t;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder producing both one-hot and binary forms.
module prio_enc #(
   parameter int unsigned N    = 2,
   parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   output logic [N-1:0]    onehot,
   output logic [IdxW-1:0] idx
);

   // Scan high to low so the lowest set request is the last one written.
   always_comb begin
      onehot = '0;
      idx    = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = IdxW'(i);
         end
      end
   end

endmodule

// File: rtl/crack_sched.sv
// Copies the length-prefixed ciphertext to all workers, launches them and
// collects the first valid key, aborting the workers that are still searching.
module crack_sched
   import crack_pkg::*;
#(
   parameter int unsigned NUM_WORKERS = 2,
   parameter int unsigned KEY_W       = KEY_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   output logic                         rdy,
   output logic [KEY_W-1:0]             key,
   output logic                         key_valid,
   output logic [7:0]                   ct_addr,
   input  logic [7:0]                   ct_rddata,
   output logic [7:0]                   copy_addr,
   output logic [7:0]                   copy_wrdata,
   output logic                         copy_wren,
   output logic [NUM_WORKERS-1:0]       wk_en,
   output logic [NUM_WORKERS*KEY_W-1:0] wk_base,
   input  logic [NUM_WORKERS-1:0]       wk_rdy,
   input  logic [NUM_WORKERS*KEY_W-1:0] wk_key,
   input  logic [NUM_WORKERS-1:0]       wk_key_valid,
   output logic [NUM_WORKERS-1:0]       wk_abort
);

   localparam int unsigned IdxW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

   sched_state_t           state_q, state_d;
   logic                   rdy_q, rdy_d;
   logic [KEY_W-1:0]       key_q, key_d;
   logic                   key_valid_q, key_valid_d;
   logic [7:0]             ct_addr_q, ct_addr_d;
   logic                   rd_pend_q, rd_pend_d;
   logic [8:0]             wr_cnt_q, wr_cnt_d;
   logic [7:0]             len_q, len_d;
   logic [7:0]             cur_len;
   logic [7:0]             copy_addr_q, copy_addr_d;
   logic [7:0]             copy_wrdata_q, copy_wrdata_d;
   logic                   copy_wren_q, copy_wren_d;
   logic [NUM_WORKERS-1:0] wk_en_q, wk_en_d;
   logic [NUM_WORKERS-1:0] wk_abort_q, wk_abort_d;
   logic [NUM_WORKERS-1:0] busy_q, busy_d;
   logic                   first_q, first_d;
   logic [NUM_WORKERS-1:0] good;
   logic [NUM_WORKERS-1:0] win_onehot;
   logic [IdxW-1:0]        win_idx;

   // Workers still show rdy during the first RUN cycle, so their status is ignored then.
   assign good = (state_q == StRun && !first_q) ? (busy_q & wk_rdy & wk_key_valid) : '0;

   prio_enc #(
      .N   (NUM_WORKERS),
      .IdxW(IdxW)
   ) u_prio_enc (
      .req   (good),
      .onehot(win_onehot),
      .idx   (win_idx)
   );

   always_comb begin
      state_d       = state_q;
      rdy_d         = rdy_q;
      key_d         = key_q;
      key_valid_d   = key_valid_q;
      ct_addr_d     = ct_addr_q;
      rd_pend_d     = 1'b0;
      wr_cnt_d      = wr_cnt_q;
      len_d         = len_q;
      cur_len       = len_q;
      copy_addr_d   = copy_addr_q;
      copy_wrdata_d = copy_wrdata_q;
      copy_wren_d   = 1'b0;
      wk_en_d       = '0;
      wk_abort_d    = '0;
      busy_d        = busy_q;
      first_d       = 1'b0;

      unique case (state_q)
         StIdle, StDoneGood, StDoneBad: begin
            if (en) begin
               state_d     = StCopy;
               rdy_d       = 1'b0;
               key_d       = '0;
               key_valid_d = 1'b0;
               ct_addr_d   = '0;
               wr_cnt_d    = '0;
            end
         end
         StCopy: begin
            rd_pend_d = 1'b1;
            // Saturate so a 256-byte copy never starts a second pass.
            if (ct_addr_q != 8'hFF) ct_addr_d = ct_addr_q + 8'd1;
            if (rd_pend_q) begin
               copy_wren_d   = 1'b1;
               copy_addr_d   = wr_cnt_q[7:0];
               copy_wrdata_d = ct_rddata;
               wr_cnt_d      = wr_cnt_q + 9'd1;
               if (wr_cnt_q == {1'b0, CT_LEN_ADDR}) begin
                  len_d   = ct_rddata;
                  cur_len = ct_rddata;
               end
               if (wr_cnt_q == {1'b0, cur_len}) begin
                  state_d   = StLaunch;
                  rd_pend_d = 1'b0;
               end
            end
         end
         StLaunch: begin
            if (&wk_rdy) begin
               wk_en_d = '1;
               busy_d  = '1;
               first_d = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            if (!first_q) begin
               if (|good) begin
                  key_d       = wk_key[win_idx*KEY_W +: KEY_W];
                  key_valid_d = 1'b1;
                  rdy_d       = 1'b1;
                  wk_abort_d  = busy_q & ~wk_rdy & ~win_onehot;
                  busy_d      = '0;
                  state_d     = StDoneGood;
               end else begin
                  busy_d = busy_q & ~wk_rdy;
                  if (busy_d == '0) begin
                     rdy_d   = 1'b1;
                     state_d = StDoneBad;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         rdy_q         <= 1'b1;
         key_q         <= '0;
         key_valid_q   <= 1'b0;
         ct_addr_q     <= '0;
         rd_pend_q     <= 1'b0;
         wr_cnt_q      <= '0;
         len_q         <= '0;
         copy_addr_q   <= '0;
         copy_wrdata_q <= '0;
         copy_wren_q   <= 1'b0;
         wk_en_q       <= '0;
         wk_abort_q    <= '0;
         busy_q        <= '0;
         first_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         rdy_q         <= rdy_d;
         key_q         <= key_d;
         key_valid_q   <= key_valid_d;
         ct_addr_q     <= ct_addr_d;
         rd_pend_q     <= rd_pend_d;
         wr_cnt_q      <= wr_cnt_d;
         len_q         <= len_d;
         copy_addr_q   <= copy_addr_d;
         copy_wrdata_q <= copy_wrdata_d;
         copy_wren_q   <= copy_wren_d;
         wk_en_q       <= wk_en_d;
         wk_abort_q    <= wk_abort_d;
         busy_q        <= busy_d;
         first_q       <= first_d;
      end
   end

   for (genvar i = 0; i < NUM_WORKERS; i++) begin : g_base
      assign wk_base[i*KEY_W +: KEY_W] = KEY_W'(i);
   end

   assign rdy         = rdy_q;
   assign key         = key_q;
   assign key_valid   = key_valid_q;
   assign ct_addr     = ct_addr_q;
   assign copy_addr   = copy_addr_q;
   assign copy_wrdata = copy_wrdata_q;
   assign copy_wren   = copy_wren_q;
   assign wk_en       = wk_en_q;
   assign wk_abort    = wk_abort_q;

endmodule

// File: tb/tb_crack_sched.sv
// Bench for crack_sched: scripted workers and a timeline model of every output.
module tb_crack_sched;

   localparam int NW = 2;
   localparam int KW = 24;
   localparam logic [NW-1:0] ALL  = '1;
   localparam logic [NW-1:0] NONE = '0;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             rdy;
   logic [KW-1:0]    key;
   logic             key_valid;
   logic [7:0]       ct_addr;
   logic [7:0]       ct_rddata;
   logic [7:0]       copy_addr;
   logic [7:0]       copy_wrdata;
   logic             copy_wren;
   logic [NW-1:0]    wk_en;
   logic [NW*KW-1:0] wk_base;
   logic [NW-1:0]    wk_rdy;
   logic [NW*KW-1:0] wk_key;
   logic [NW-1:0]    wk_key_valid;
   logic [NW-1:0]    wk_abort;

   always #5 clk = ~clk;

   crack_sched #(
      .NUM_WORKERS(NW),
      .KEY_W      (KW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .rdy         (rdy),
      .key         (key),
      .key_valid   (key_valid),
      .ct_addr     (ct_addr),
      .ct_rddata   (ct_rddata),
      .copy_addr   (copy_addr),
      .copy_wrdata (copy_wrdata),
      .copy_wren   (copy_wren),
      .wk_en       (wk_en),
      .wk_base     (wk_base),
      .wk_rdy      (wk_rdy),
      .wk_key      (wk_key),
      .wk_key_valid(wk_key_valid),
      .wk_abort    (wk_abort)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mem [256];
   always @(posedge clk) ct_rddata <= mem[ct_addr];

   // Transaction description and derived timeline.
   int            dly [NW];
   bit            vld [NW];
   logic [KW-1:0] kk  [NW];
   int            f_fin [NW];
   int            s, len_c, t_launch, d_done, win;
   bit            good;
   logic [NW-1:0] ab_mask;
   logic          prev_kv = 1'b0;
   logic [KW-1:0] prev_key = '0;
   bit            chk_on = 1'b0;

   int            wr_obs, ab_cnt, first_wc;
   logic [NW-1:0] ab_val;
   logic [7:0]    first_wa, first_wd;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         if (cyc == s) begin
            wr_obs = 0;
            ab_cnt = 0;
            ab_val = '0;
         end
         chk("rdy", rdy, (cyc <= s) ? 1 : (cyc >= d_done));
         chk("key_valid", key_valid, (cyc <= s) ? prev_kv : ((cyc >= d_done) ? good : 0));
         chk("key", key, (cyc <= s) ? prev_key : ((cyc >= d_done && good) ? kk[win] : 0));
         chk("copy_wren", copy_wren, (cyc >= s + 3 && cyc <= s + 3 + len_c));
         if (cyc >= s + 3 && cyc <= s + 3 + len_c) begin
            chk("copy_addr", copy_addr, cyc - s - 3);
            chk("copy_wrdata", copy_wrdata, mem[cyc-s-3]);
         end
         if (copy_wren) begin
            if (wr_obs == 0) begin
               first_wc = cyc - s;
               first_wa = copy_addr;
               first_wd = copy_wrdata;
            end
            wr_obs++;
         end
         if (cyc >= s + 1 && cyc <= s + 1 + len_c) chk("ct_addr", ct_addr, cyc - s - 1);
         if (len_c == 255 && cyc == s + len_c + 2) chk("ct_addr_nowrap", ct_addr != 0, 1);
         chk("wk_en", wk_en, (cyc == t_launch) ? ALL : NONE);
         chk("wk_abort", wk_abort, (good && cyc == d_done) ? ab_mask : NONE);
         if (wk_abort != '0) begin
            ab_cnt++;
            ab_val = wk_abort;
         end
      end
   end

   task automatic fill_mem(input int l);
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
      mem[0] = 8'(l);
   endtask

   // Runs one en..DONE transaction with scripted workers; rst_off>0 pulls reset
   // that many cycles after launch instead of letting the search complete.
   task automatic run_txn(input int l, input int st, input int rst_off, input bit noise);
      int  fw, mx, end_c, rel;
      bit  abd;
      s        = cyc;
      len_c    = l;
      t_launch = s + l + 4 + st;
      good     = 1'b0;
      win      = 0;
      fw       = 1 << 30;
      mx       = 0;
      for (int i = 0; i < NW; i++) begin
         f_fin[i] = t_launch + 1 + dly[i];
         if (f_fin[i] > mx) mx = f_fin[i];
         if (vld[i] && f_fin[i] < fw) begin
            fw   = f_fin[i];
            win  = i;
            good = 1'b1;
         end
         wk_key[i*KW +: KW] = kk[i];
      end
      ab_mask = '0;
      if (good) begin
         d_done = fw + 1;
         for (int i = 0; i < NW; i++) ab_mask[i] = (f_fin[i] > fw);
      end else begin
         d_done = mx + 1;
      end
      end_c  = (rst_off > 0) ? t_launch + rst_off : d_done + 2;
      chk_on = 1'b1;
      for (int c = s; c <= end_c; c++) begin
         en = (c == s) || (noise && c > s && c < d_done && $urandom_range(0, 3) == 0);
         for (int i = 0; i < NW; i++) begin
            abd = good && (f_fin[i] > fw);
            rel = abd ? fw + 2 : f_fin[i];
            wk_rdy[i] = !((i == 0 && st > 0 && c >= s + 1 && c < s + l + 3 + st) ||
                          (c >= t_launch + 1 && c < rel));
            wk_key_valid[i] = vld[i] && !abd && (c >= f_fin[i]);
         end
         if (rst_off > 0 && c == end_c) rst_n = 1'b0;
         @(posedge clk);
         #1;
      end
      en     = 1'b0;
      chk_on = 1'b0;
      if (rst_off > 0) begin
         wk_rdy       = '1;
         wk_key_valid = '0;
         @(negedge clk);
         chk("rst_rdy", rdy, 1);
         chk("rst_wk_en", wk_en, 0);
         chk("rst_key_valid", key_valid, 0);
         chk("rst_key", key, 0);
         chk("rst_copy_wren", copy_wren, 0);
         chk("rst_ct_addr", ct_addr, 0);
         chk("rst_wk_abort", wk_abort, 0);
         @(posedge clk);
         #1;
         rst_n    = 1'b1;
         prev_kv  = 1'b0;
         prev_key = '0;
      end else begin
         prev_kv  = good;
         prev_key = good ? kk[win] : '0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n        = 1'b0;
      en           = 1'b0;
      wk_rdy       = '1;
      wk_key_valid = '0;
      wk_key       = '0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_rdy", rdy, 1);
      chk("reset_key_valid", key_valid, 0);
      chk("reset_key", key, 0);
      chk("reset_ct_addr", ct_addr, 0);
      chk("reset_copy_wren", copy_wren, 0);
      chk("reset_copy_addr", copy_addr, 0);
      chk("reset_copy_wrdata", copy_wrdata, 0);
      chk("reset_wk_en", wk_en, 0);
      chk("reset_wk_abort", wk_abort, 0);
      chk("wk_base", wk_base, {24'd1, 24'd0});
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // L=3 copy; worker 1 wins while worker 0 still busy.
      fill_mem(3);
      mem[1] = 8'hAA;
      mem[2] = 8'hBB;
      mem[3] = 8'hCC;
      dly[0] = 10; vld[0] = 1'b0; kk[0] = 24'h000099;
      dly[1] = 3;  vld[1] = 1'b1; kk[1] = 24'h000017;
      run_txn(3, 0, 0, 1'b0);
      chk("t1_writes", wr_obs, 4);
      chk("t1_first_wr_cycle", first_wc, 3);
      chk("t1_first_addr", first_wa, 8'h00);
      chk("t1_first_data", first_wd, 8'h03);
      chk("t1_key", key, 24'h000017);
      chk("t1_key_valid", key_valid, 1);
      chk("t1_abort_cycles", ab_cnt, 1);
      chk("t1_abort_mask", ab_val, 2'b01);

      // Simultaneous valid results resolve to the lowest index.
      fill_mem(5);
      dly[0] = 4; vld[0] = 1'b1; kk[0] = 24'h00002A;
      dly[1] = 4; vld[1] = 1'b1; kk[1] = 24'h00002B;
      run_txn(5, 1, 0, 1'b1);
      chk("t2_key", key, 24'h00002A);
      chk("t2_abort_cycles", ab_cnt, 0);

      // Nobody finds a key.
      fill_mem(2);
      dly[0] = 2; vld[0] = 1'b0;
      dly[1] = 6; vld[1] = 1'b0;
      run_txn(2, 0, 0, 1'b1);
      chk("t3_rdy", rdy, 1);
      chk("t3_key_valid", key_valid, 0);
      chk("t3_key", key, 0);

      // Length boundaries, with a launch stall on the short one.
      fill_mem(0);
      dly[0] = 1; vld[0] = 1'b1; kk[0] = 24'h000100;
      dly[1] = 2; vld[1] = 1'b0;
      run_txn(0, 3, 0, 1'b0);
      chk("t4_writes", wr_obs, 1);
      fill_mem(255);
      dly[0] = 5; vld[0] = 1'b0;
      dly[1] = 3; vld[1] = 1'b0;
      run_txn(255, 0, 0, 1'b0);
      chk("t5_writes", wr_obs, 256);

      // Reset mid-RUN, then a full fresh copy.
      fill_mem(4);
      dly[0] = 20; vld[0] = 1'b1;
      dly[1] = 20; vld[1] = 1'b1;
      run_txn(4, 0, 5, 1'b0);
      fill_mem(6);
      dly[0] = 2; vld[0] = 1'b0;
      dly[1] = 7; vld[1] = 1'b1; kk[1] = 24'hABCDEF;
      run_txn(6, 0, 0, 1'b0);
      chk("t7_writes", wr_obs, 7);
      chk("t7_first_addr", first_wa, 8'h00);
      chk("t7_key", key, 24'hABCDEF);

      for (int n = 0; n < 30; n++) begin
         int l;
         l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
         fill_mem(l);
         for (int i = 0; i < NW; i++) begin
            dly[i] = int'($urandom_range(1, 12));
            vld[i] = 1'($urandom_range(0, 1));
            kk[i]  = KW'($urandom);
         end
         run_txn(l, int'($urandom_range(0, 3)), 0, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
